pitch_shift_ctrl: RTL

// - Sequencer/configurator for the pitch-shifter datapath. Takes user requests (enable, ratio),

---
 rtl/audio_pkg.sv | 34 +++
 rtl/pitch_shift_ctrl_if.sv | 22 ++
 rtl/sat_ramp.sv | 29 ++
 rtl/pitch_shift_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants, state encoding and ratio clamp for the pitch-shift sequencer.
package audio_pkg;

    localparam logic [15:0] UNITY_RATIO = 16'h0100;
    localparam logic [15:0] UNITY_GAIN  = 16'hFFFF;
    localparam logic [15:0] MIN_RATIO   = 16'h0080;
    localparam logic [15:0] MAX_RATIO   = 16'h0200;
    localparam logic [15:0] GLIDE_STEP  = 16'h0004;
    localparam logic [15:0] FADE_STEP   = 16'h0400;
    localparam int unsigned FLUSH_TICKS = 64;
    localparam int unsigned FLUSH_W     = 7;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = 7'(FLUSH_TICKS - 1);

    typedef enum logic [2:0] {
        BYPASS   = 3'd0,
        ACTIVE   = 3'd1,
        FADE_OUT = 3'd2,
        SWITCH   = 3'd3,
        FADE_IN  = 3'd4
    } psc_state_t;

    function automatic logic [15:0] clamp_ratio(input logic [15:0] ratio);
        logic [15:0] res;
        if (ratio < MIN_RATIO) begin
            res = MIN_RATIO;
        end else if (ratio > MAX_RATIO) begin
            res = MAX_RATIO;
        end else begin
            res = ratio;
        end
        return res;
    endfunction

endpackage

// File: rtl/pitch_shift_ctrl_if.sv
// Request/response and shifter-control bundle between the host side and the sequencer.
interface pitch_shift_ctrl_if;
    logic        tick;
    logic        req_valid;
    logic        req_ready;
    logic        req_enable;
    logic [15:0] req_ratio;
    logic        shifter_enable;
    logic [15:0] pitch_ratio;
    logic [15:0] fade_gain;
    logic        busy;

    modport master (
        output tick, req_valid, req_enable, req_ratio,
        input  req_ready, shifter_enable, pitch_ratio, fade_gain, busy
    );

    modport slave (
        input  tick, req_valid, req_enable, req_ratio,
        output req_ready, shifter_enable, pitch_ratio, fade_gain, busy
    );
endinterface

// File: rtl/sat_ramp.sv
// Moves a 16-bit value toward a target by at most one step; never overshoots or wraps.
module sat_ramp (
    input  logic [15:0] value_i,
    input  logic [15:0] target_i,
    input  logic [15:0] step_i,
    input  logic        advance_i,
    output logic [15:0] next_o,
    output logic        at_target_o
);
    logic signed [16:0] diff_s;
    logic signed [16:0] step_s;

    // Signed 17-bit distance decides between a full step and snapping onto the target.
    always_comb begin
        diff_s = $signed({1'b0, target_i}) - $signed({1'b0, value_i});
        step_s = $signed({1'b0, step_i});
        if (!advance_i) begin
            next_o = value_i;
        end else if (diff_s > step_s) begin
            next_o = value_i + step_i;
        end else if (diff_s < -step_s) begin
            next_o = value_i - step_i;
        end else begin
            next_o = target_i;
        end
    end

    assign at_target_o = (next_o == target_i);
endmodule

// File: rtl/pitch_shift_ctrl.sv
// Pitch-shifter sequencer: ratio glide while active and a mute/switch/unmute
// sequence around enable changes.
module pitch_shift_ctrl
    import audio_pkg::*;
(
    input  logic               CLOCK_50,
    input  logic               resetn,
    pitch_shift_ctrl_if.slave  bus
);
    psc_state_t           state_q, state_d;
    logic                 shifter_enable_q, shifter_enable_d;
    logic [15:0]          pitch_ratio_q, pitch_ratio_d;
    logic [15:0]          fade_gain_q, fade_gain_d;
    logic [15:0]          target_ratio_q, target_ratio_d;
    logic                 target_en_q, target_en_d;
    logic [FLUSH_W-1:0]   flush_q, flush_d;

    logic                 accept_s;
    logic [15:0]          req_clamped_s;
    logic [15:0]          ratio_next_s, gain_next_s, gain_tgt_s;
    logic                 ratio_at_s, gain_at_s;

    assign bus.req_ready      = (state_q == BYPASS) || (state_q == ACTIVE);
    assign accept_s           = bus.req_valid && bus.req_ready;
    assign req_clamped_s      = clamp_ratio(bus.req_ratio);
    assign gain_tgt_s         = (state_q == FADE_IN) ? UNITY_GAIN : 16'h0000;

    assign bus.shifter_enable = shifter_enable_q;
    assign bus.pitch_ratio    = pitch_ratio_q;
    assign bus.fade_gain      = fade_gain_q;
    assign bus.busy           = (state_q == FADE_OUT) || (state_q == SWITCH) || (state_q == FADE_IN);

    sat_ramp u_ratio_ramp (
        .value_i     (pitch_ratio_q),
        .target_i    (target_ratio_q),
        .step_i      (GLIDE_STEP),
        .advance_i   (bus.tick),
        .next_o      (ratio_next_s),
        .at_target_o (ratio_at_s)
    );

    sat_ramp u_gain_ramp (
        .value_i     (fade_gain_q),
        .target_i    (gain_tgt_s),
        .step_i      (FADE_STEP),
        .advance_i   (bus.tick),
        .next_o      (gain_next_s),
        .at_target_o (gain_at_s)
    );

    // Next-state and register updates; tick steps always use the pre-accept registers.
    always_comb begin
        state_d          = state_q;
        shifter_enable_d = shifter_enable_q;
        pitch_ratio_d    = pitch_ratio_q;
        fade_gain_d      = fade_gain_q;
        target_ratio_d   = target_ratio_q;
        target_en_d      = target_en_q;
        flush_d          = flush_q;
        case (state_q)
            BYPASS: begin
                if (accept_s) begin
                    target_ratio_d = req_clamped_s;
                    target_en_d    = bus.req_enable;
                    // Shifter is off, so the ratio can jump without being heard.
                    if (bus.req_enable) begin
                        state_d = FADE_OUT;
                    end else begin
                        pitch_ratio_d = req_clamped_s;
                    end
                end else begin
                    state_d = BYPASS;
                end
            end
            ACTIVE: begin
                if (bus.tick) begin
                    pitch_ratio_d = ratio_at_s ? target_ratio_q : ratio_next_s;
                end else begin
                    pitch_ratio_d = pitch_ratio_q;
                end
                if (accept_s) begin
                    target_ratio_d = req_clamped_s;
                    target_en_d    = bus.req_enable;
                    state_d        = bus.req_enable ? ACTIVE : FADE_OUT;
                end else begin
                    state_d = ACTIVE;
                end
            end
            FADE_OUT: begin
                if (bus.tick) begin
                    fade_gain_d = gain_next_s;
                    if (gain_at_s) begin
                        state_d          = SWITCH;
                        shifter_enable_d = target_en_q;
                        pitch_ratio_d    = target_ratio_q;
                        flush_d          = 7'd0;
                    end else begin
                        state_d = FADE_OUT;
                    end
                end else begin
                    state_d = FADE_OUT;
                end
            end
            SWITCH: begin
                if (bus.tick) begin
                    flush_d = flush_q + 7'd1;
                    state_d = (flush_q == FLUSH_LAST) ? FADE_IN : SWITCH;
                end else begin
                    state_d = SWITCH;
                end
            end
            FADE_IN: begin
                if (bus.tick) begin
                    fade_gain_d = gain_next_s;
                    if (gain_at_s) begin
                        state_d = shifter_enable_q ? ACTIVE : BYPASS;
                    end else begin
                        state_d = FADE_IN;
                    end
                end else begin
                    state_d = FADE_IN;
                end
            end
            default: begin
                state_d = BYPASS;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q          <= BYPASS;
            shifter_enable_q <= 1'b0;
            pitch_ratio_q    <= UNITY_RATIO;
            fade_gain_q      <= UNITY_GAIN;
            target_ratio_q   <= UNITY_RATIO;
            target_en_q      <= 1'b0;
            flush_q          <= 7'd0;
        end else begin
            state_q          <= state_d;
            shifter_enable_q <= shifter_enable_d;
            pitch_ratio_q    <= pitch_ratio_d;
            fade_gain_q      <= fade_gain_d;
            target_ratio_q   <= target_ratio_d;
            target_en_q      <= target_en_d;
            flush_q          <= flush_d;
        end
    end
endmodule
